// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt concentrator: synchronises raw sources, latches them per
// edge/level mode, masks them and presents the lowest-index active source.
module irq_aggregator #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic [15:0]        readdata,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_LOST    = 3'd5;
    localparam logic [2:0] ADDR_FORCE   = 3'd6;
    localparam logic [2:0] ADDR_RAW     = 3'd7;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [15:0]        lost_q;

    logic               wr;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] force_set;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] edge_next;
    logic [NUM_SRC-1:0] pending_next;
    logic               collide;
    logic [3:0]         lowest_id;
    logic [15:0]        read_mux;

    function automatic logic [15:0] widen(input logic [NUM_SRC-1:0] v);
        widen = '0;
        widen[NUM_SRC-1:0] = v;
    endfunction

    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[NUM_SRC-1:0];
    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~prev_q;
    assign w1c       = (wr && address == ADDR_PENDING) ? wdata : '0;
    assign force_set = (wr && address == ADDR_FORCE) ? wdata : '0;
    assign active    = pending_q & mask_q;

    // Set (rise or force) beats a same-cycle W1C; level bits just track the input.
    assign edge_next    = (pending_q & ~w1c) | rise | force_set;
    assign pending_next = (mode_q & edge_next) | (~mode_q & s);
    assign collide      = |(mode_q & rise & pending_q & ~w1c);

    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) lowest_id = 4'(i);
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_PENDING: read_mux = widen(pending_q);
            ADDR_MASK:    read_mux = widen(mask_q);
            ADDR_MODE:    read_mux = widen(mode_q);
            ADDR_ACTIVE:  read_mux = widen(active);
            ADDR_VECTOR:  read_mux = {|active, 11'd0, lowest_id};
            ADDR_LOST:    read_mux = lost_q;
            ADDR_FORCE:   read_mux = '0;
            ADDR_RAW:     read_mux = widen(s);
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // prev runs regardless of mode so switching to edge mode never fakes a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
        end else begin
            prev_q    <= s;
            pending_q <= pending_next;
            if (wr && address == ADDR_MASK) mask_q <= wdata;
            if (wr && address == ADDR_MODE) mode_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost_q <= '0;
        end else if (wr && address == ADDR_LOST) begin
            lost_q <= '0;
        end else if (collide && lost_q != 16'hFFFF) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
            irq_id   <= '0;
        end else begin
            readdata <= read_mux;
            irq      <= |active;
            irq_id   <= lowest_id;
        end
    end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed self-checking bench for irq_aggregator (NUM_SRC=8, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_aggregator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [7:0]  irq_in = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [3:0]  irq_id;

    int n_compared = 0;
    int n_mismatched = 0;

    irq_aggregator #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset_n = 1'b0;
        irq_in = 8'hFF;
        repeat (3) @(negedge clk);
        n_compared++;
        if (readdata !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL reset_readdata got %h want 0000", readdata);
        end
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL reset_irq got %b want 0", irq);
        end
        n_compared++;
        if (irq_id !== 4'd0) begin
            n_mismatched++; $display("[TB] FAIL reset_irq_id got %0d want 0", irq_id);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h00FF) begin
            n_mismatched++; $display("[TB] FAIL reset_pending_level got %h want 00ff", d);
        end
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL reset_masked_irq got %b want 0", irq);
        end
        irq_in = 8'h00;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_edge_latency();
        logic [15:0] d;
        bus_write(3'd2, 16'h0001);
        bus_write(3'd1, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL edge_irq_early got %b want 0", irq);
        end
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL edge_irq_latency got %b want 1", irq);
        end
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0001) begin
            n_mismatched++; $display("[TB] FAIL edge_pending got %h want 0001", d);
        end
        bus_read(3'd4, d);
        n_compared++;
        if (d !== 16'h8000) begin
            n_mismatched++; $display("[TB] FAIL edge_vector got %h want 8000", d);
        end
        bus_write(3'd0, 16'h0001);
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL w1c_irq_hold got %b want 1", irq);
        end
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL w1c_irq_drop got %b want 0", irq);
        end
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL w1c_pending got %h want 0000", d);
        end
    endtask

    task automatic test_priority();
        logic [15:0] d;
        bus_write(3'd2, 16'h00FF);
        bus_write(3'd1, 16'h00FF);
        bus_write(3'd6, 16'h0024);
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b1 || irq_id !== 4'd2) begin
            n_mismatched++; $display("[TB] FAIL prio_first got irq=%b id=%0d want irq=1 id=2", irq, irq_id);
        end
        bus_read(3'd4, d);
        n_compared++;
        if (d !== 16'h8002) begin
            n_mismatched++; $display("[TB] FAIL prio_vector got %h want 8002", d);
        end
        bus_read(3'd6, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL force_reads_zero got %h want 0000", d);
        end
        bus_write(3'd0, 16'h0004);
        @(negedge clk);
        n_compared++;
        if (irq_id !== 4'd5) begin
            n_mismatched++; $display("[TB] FAIL prio_second got id=%0d want 5", irq_id);
        end
        bus_write(3'd0, 16'h0020);
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b0 || irq_id !== 4'd0) begin
            n_mismatched++; $display("[TB] FAIL prio_empty got irq=%b id=%0d want irq=0 id=0", irq, irq_id);
        end
    endtask

    task automatic test_collision_lost();
        logic [15:0] d;
        bus_write(3'd6, 16'h0002);
        // Rise of bit 1 reaches the pending logic in the same cycle as its W1C.
        @(negedge clk);
        irq_in[1] = 1'b1;
        @(negedge clk);
        bus_write(3'd0, 16'h0002);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0002) begin
            n_mismatched++; $display("[TB] FAIL collide_pending got %h want 0002", d);
        end
        bus_read(3'd5, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL collide_lost got %h want 0000", d);
        end
        irq_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        irq_in[1] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd5, d);
        n_compared++;
        if (d !== 16'h0001) begin
            n_mismatched++; $display("[TB] FAIL lost_count got %h want 0001", d);
        end
        bus_write(3'd5, 16'h1234);
        bus_read(3'd5, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL lost_clear got %h want 0000", d);
        end
        // Alternate bits 0 and 1 so one pending edge bit rises every cycle.
        bus_write(3'd6, 16'h0003);
        for (int i = 0; i < 65560; i++) begin
            @(negedge clk);
            irq_in[1:0] = (i % 2 == 0) ? 2'b01 : 2'b10;
        end
        @(negedge clk);
        irq_in[1:0] = 2'b00;
        repeat (5) @(negedge clk);
        bus_read(3'd5, d);
        n_compared++;
        if (d !== 16'hFFFF) begin
            n_mismatched++; $display("[TB] FAIL lost_saturate got %h want ffff", d);
        end
    endtask

    task automatic test_level_mask();
        logic [15:0] d;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h0008);
        @(negedge clk);
        irq_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        n_compared++;
        if (irq !== 1'b1 || irq_id !== 4'd3) begin
            n_mismatched++; $display("[TB] FAIL level_irq got irq=%b id=%0d want irq=1 id=3", irq, irq_id);
        end
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0008) begin
            n_mismatched++; $display("[TB] FAIL level_w1c_ignored got %h want 0008", d);
        end
        @(negedge clk);
        irq_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL level_fall_early got %b want 1", irq);
        end
        @(negedge clk);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL level_fall_latency got %b want 0", irq);
        end
        irq_in[2] = 1'b1;
        repeat (5) @(negedge clk);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL masked_irq got %b want 0", irq);
        end
        bus_read(3'd3, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL masked_active got %h want 0000", d);
        end
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0004) begin
            n_mismatched++; $display("[TB] FAIL masked_pending got %h want 0004", d);
        end
        irq_in[2] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mode_switch();
        logic [15:0] d;
        irq_in[4] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd7, d);
        n_compared++;
        if (d !== 16'h0010) begin
            n_mismatched++; $display("[TB] FAIL raw_read got %h want 0010", d);
        end
        bus_write(3'd2, 16'h0010);
        bus_write(3'd0, 16'h0010);
        repeat (5) @(negedge clk);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL switch_no_edge got %h want 0000", d);
        end
        irq_in[4] = 1'b0;
        repeat (4) @(negedge clk);
        irq_in[4] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0010) begin
            n_mismatched++; $display("[TB] FAIL switch_new_edge got %h want 0010", d);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] d;
        bus_write(3'd1, 16'h0010);
        repeat (2) @(negedge clk);
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL midop_irq_before got %b want 1", irq);
        end
        #2 reset_n = 1'b0;
        #1;
        n_compared++;
        if (irq !== 1'b0 || irq_id !== 4'd0) begin
            n_mismatched++; $display("[TB] FAIL midop_async_clear got irq=%b id=%0d want irq=0 id=0", irq, irq_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd0, d);
        n_compared++;
        if (d !== 16'h0010) begin
            n_mismatched++; $display("[TB] FAIL midop_repend_level got %h want 0010", d);
        end
        bus_read(3'd2, d);
        n_compared++;
        if (d !== 16'h0000) begin
            n_mismatched++; $display("[TB] FAIL midop_mode_cleared got %h want 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_collision_lost();
        test_level_mask();
        test_mode_switch();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
